// File: rtl/sram_port0_rr_arbiter.sv
// Round-robin arbiter sharing port 0 (RW) of a 1rw1r OpenRAM macro between NUM_REQ requesters.
// Every macro input is registered; responses return two edges after accept, in accept order.
module sram_port0_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*NUM_WMASKS-1:0]    req_wmask,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,

    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic                             rsp_is_read,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,

    output logic                             sram_csb0,
    output logic                             sram_web0,
    output logic [NUM_WMASKS-1:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0]            sram_addr0,
    output logic [DATA_WIDTH-1:0]            sram_din0,
    input  logic [DATA_WIDTH-1:0]            sram_dout0
);

    localparam int unsigned PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_WIDTH-1:0]  ptr;
    logic [PTR_WIDTH-1:0]  next_ptr;
    logic [PTR_WIDTH:0]    scan_idx;
    logic [PTR_WIDTH-1:0]  grant_idx;
    logic                  grant_any;
    logic [NUM_REQ-1:0]    grant;

    logic                  sel_we;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic [NUM_REQ-1:0]    s1_id;
    logic                  s1_read;
    logic [NUM_REQ-1:0]    s2_id;
    logic                  s2_read;

    // Scan requesters starting at ptr; first valid one wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr} + (PTR_WIDTH + 1)'(k);
            if (scan_idx >= (PTR_WIDTH + 1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PTR_WIDTH + 1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[scan_idx[PTR_WIDTH-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[PTR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_any && (grant_idx == PTR_WIDTH'(i))) begin
                grant[i] = 1'b1;
            end
        end
    end

    assign req_ready = rst ? '0 : grant;

    assign next_ptr = (grant_idx == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        sel_we    = 1'b0;
        sel_wmask = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_wmask = req_wmask[i*NUM_WMASKS +: NUM_WMASKS];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Issue stage: address/data hold when idle, control returns to deselected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else if (grant_any) begin
            ptr         <= next_ptr;
            sram_csb0   <= 1'b0;
            sram_web0   <= ~sel_we;
            sram_wmask0 <= sel_we ? sel_wmask : '0;
            sram_addr0  <= sel_addr;
            sram_din0   <= sel_wdata;
        end else begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
        end
    end

    // Stage 1 lines up with the issue registers, stage 2 with the macro's capture cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_id   <= '0;
            s1_read <= 1'b0;
            s2_id   <= '0;
            s2_read <= 1'b0;
        end else begin
            s1_id   <= grant;
            s1_read <= grant_any & ~sel_we;
            s2_id   <= s1_id;
            s2_read <= s1_read;
        end
    end

    assign rsp_valid   = s2_id;
    assign rsp_is_read = s2_read;
    assign rsp_rdata   = s2_read ? sram_dout0 : '0;

endmodule

// File: tb/tb_sram_port0_rr_arbiter.sv
// Bench for sram_port0_rr_arbiter: behavioural macro, random traffic against a reference model,
// a directed vector table and hand-written reset sequences.
module tb_sram_port0_rr_arbiter;

    localparam int NR = 2;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int NM = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, req_we, rsp_valid;
    logic [NR*NM-1:0]  req_wmask;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic              rsp_is_read;
    logic [DW-1:0]     rsp_rdata;
    logic              sram_csb0, sram_web0;
    logic [NM-1:0]     sram_wmask0;
    logic [AW-1:0]     sram_addr0;
    logic [DW-1:0]     sram_din0, sram_dout0;

    always #5 clk = ~clk;

    sram_port0_rr_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WMASKS (NM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_wmask   (req_wmask),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_is_read (rsp_is_read),
        .rsp_rdata   (rsp_rdata),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    // Macro model: capture on posedge, write or read out on the following negedge.
    logic          mem_init;
    logic [DW-1:0] mem [512];
    logic          cap_csb, cap_web;
    logic [NM-1:0] cap_mask;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_din;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        cap_csb  <= sram_csb0;
        cap_web  <= sram_web0;
        cap_mask <= sram_wmask0;
        cap_addr <= sram_addr0;
        cap_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
            sram_dout0 <= '0;
        end else if (cap_csb == 1'b0) begin
            if (cap_web == 1'b0) begin
                for (int b = 0; b < NM; b++)
                    if (cap_mask[b]) mem[cap_addr][b*8 +: 8] <= cap_din[b*8 +: 8];
            end else begin
                sram_dout0 <= mem[cap_addr];
            end
        end
    end

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [8:0] a0,
                         input logic [8:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [3:0] m0, input logic [3:0] m1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        req_wmask = {m1, m0};
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] v, input logic rd,
                             input logic [31:0] data);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(v));
        check({tag, "_rsp_is_read"}, 64'(rsp_is_read), 64'(rd));
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(data));
    endtask

    // Reference model: round-robin pointer, shadow memory and a queue of responses with due cycle.
    typedef struct {
        int          due;
        logic [1:0]  id;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    int          ref_ptr;
    logic [31:0] shadow [512];
    exp_t        expq[$];

    task automatic run_random(input int ncyc);
        logic [1:0]  v, we, exp_ready;
        logic [8:0]  a [2];
        logic [31:0] d [2];
        logic [3:0]  m [2];
        int          g;
        exp_t        e;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            v  = 2'($urandom_range(0, 3));
            we = 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++) begin
                a[r] = 9'($urandom_range(0, 15));
                d[r] = $urandom();
                m[r] = 4'($urandom_range(0, 15));
            end
            drive(v, we, a[0], a[1], d[0], d[1], m[0], m[1]);
            #1;
            g = -1;
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (ref_ptr + k) % NR;
                if (g < 0 && v[idx]) g = idx;
            end
            exp_ready = (g < 0) ? 2'b00 : 2'(1 << g);
            check($sformatf("rand%0d_ready", c), 64'(req_ready), 64'(exp_ready));
            if (g >= 0) begin
                e.due = c + 2;
                e.id  = 2'(1 << g);
                if (we[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (m[g][b]) shadow[a[g]][b*8 +: 8] = d[g][b*8 +: 8];
                    e.rd   = 1'b0;
                    e.data = 32'h0;
                end else begin
                    e.rd   = 1'b1;
                    e.data = shadow[a[g]];
                end
                expq.push_back(e);
                ref_ptr = (g + 1) % NR;
            end
            @(negedge clk);
            #1;
            if (expq.size() > 0 && expq[0].due == c) begin
                e = expq.pop_front();
                check_rsp($sformatf("rand%0d", c), e.id, e.rd, e.data);
            end else begin
                check_rsp($sformatf("rand%0d", c), 2'b00, 1'b0, 32'h0);
            end
        end
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  we;
        logic [8:0]  a0;
        logic [8:0]  a1;
        logic [31:0] d;
        logic [3:0]  m;
        logic [1:0]  ready;
        logic [1:0]  rsp;
        logic        rd;
        logic [31:0] rdata;
    } row_t;

    row_t tbl[$];

    task automatic add(input logic [1:0] v, input logic [1:0] we, input logic [8:0] a0,
                       input logic [8:0] a1, input logic [31:0] d, input logic [3:0] m,
                       input logic [1:0] ready, input logic [1:0] rsp, input logic rd,
                       input logic [31:0] rdata);
        row_t r;
        r.v = v; r.we = we; r.a0 = a0; r.a1 = a1; r.d = d; r.m = m;
        r.ready = ready; r.rsp = rsp; r.rd = rd; r.rdata = rdata;
        tbl.push_back(r);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        ref_ptr  = 0;
        mem_init = 1'b1;
        rst      = 1'b1;
        idle();
        for (int i = 0; i < 512; i++) shadow[i] = init_word(i);

        @(negedge clk);
        #1;
        check("reset_csb0", 64'(sram_csb0), 64'(1));
        check("reset_web0", 64'(sram_web0), 64'(1));
        check("reset_wmask0", 64'(sram_wmask0), 64'(0));
        check("reset_addr0", 64'(sram_addr0), 64'(0));
        check("reset_din0", 64'(sram_din0), 64'(0));
        check_rsp("reset", 2'b00, 1'b0, 32'h0);
        req_valid = 2'b11;
        #1;
        check("reset_ready_blocked", 64'(req_ready), 64'(0));
        idle();

        @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst      = 1'b0;

        run_random(400);

        pulse_reset();
        // write/read, masked write, alternating grants, cross-requester RAW, zero-mask write
        add(2'd1, 2'd1, 9'h005, 9'h000, 32'hDEADBEEF, 4'hF, 2'd1, 2'd0, 1'b0, 32'h0);
        add(2'd1, 2'd0, 9'h005, 9'h000, 32'h0,        4'h0, 2'd1, 2'd0, 1'b0, 32'h0);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd1, 1'b0, 32'h0);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd1, 1'b1, 32'hDEADBEEF);
        add(2'd1, 2'd1, 9'h010, 9'h000, 32'h11223344, 4'hF, 2'd1, 2'd0, 1'b0, 32'h0);
        add(2'd1, 2'd1, 9'h010, 9'h000, 32'hAABBCCDD, 4'h2, 2'd1, 2'd0, 1'b0, 32'h0);
        add(2'd1, 2'd0, 9'h010, 9'h000, 32'h0,        4'h0, 2'd1, 2'd1, 1'b0, 32'h0);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd1, 1'b0, 32'h0);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd1, 1'b1, 32'h1122CC44);
        add(2'd1, 2'd1, 9'h001, 9'h000, 32'h01010101, 4'hF, 2'd1, 2'd0, 1'b0, 32'h0);
        add(2'd2, 2'd2, 9'h000, 9'h002, 32'h02020202, 4'hF, 2'd2, 2'd0, 1'b0, 32'h0);
        add(2'd3, 2'd0, 9'h001, 9'h002, 32'h0,        4'h0, 2'd1, 2'd1, 1'b0, 32'h0);
        add(2'd3, 2'd0, 9'h001, 9'h002, 32'h0,        4'h0, 2'd2, 2'd2, 1'b0, 32'h0);
        add(2'd3, 2'd0, 9'h001, 9'h002, 32'h0,        4'h0, 2'd1, 2'd1, 1'b1, 32'h01010101);
        add(2'd3, 2'd0, 9'h001, 9'h002, 32'h0,        4'h0, 2'd2, 2'd2, 1'b1, 32'h02020202);
        add(2'd3, 2'd0, 9'h001, 9'h002, 32'h0,        4'h0, 2'd1, 2'd1, 1'b1, 32'h01010101);
        add(2'd3, 2'd0, 9'h001, 9'h002, 32'h0,        4'h0, 2'd2, 2'd2, 1'b1, 32'h02020202);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd1, 1'b1, 32'h01010101);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd2, 1'b1, 32'h02020202);
        add(2'd2, 2'd2, 9'h000, 9'h1FF, 32'hCAFEF00D, 4'hF, 2'd2, 2'd0, 1'b0, 32'h0);
        add(2'd1, 2'd0, 9'h1FF, 9'h000, 32'h0,        4'h0, 2'd1, 2'd0, 1'b0, 32'h0);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd2, 1'b0, 32'h0);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd1, 1'b1, 32'hCAFEF00D);
        add(2'd1, 2'd1, 9'h005, 9'h000, 32'hFFFFFFFF, 4'h0, 2'd1, 2'd0, 1'b0, 32'h0);
        add(2'd1, 2'd0, 9'h005, 9'h000, 32'h0,        4'h0, 2'd1, 2'd0, 1'b0, 32'h0);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd1, 1'b0, 32'h0);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd1, 1'b1, 32'hDEADBEEF);
        add(2'd2, 2'd0, 9'h000, 9'h010, 32'h0,        4'h0, 2'd2, 2'd0, 1'b0, 32'h0);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd0, 1'b0, 32'h0);
        add(2'd0, 2'd0, 9'h000, 9'h000, 32'h0,        4'h0, 2'd0, 2'd2, 1'b1, 32'h1122CC44);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d, tbl[i].d,
                  tbl[i].m, tbl[i].m);
            #1;
            check($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].ready));
            @(negedge clk);
            #1;
            check_rsp($sformatf("tbl%0d", i), tbl[i].rsp, tbl[i].rd, tbl[i].rdata);
        end

        // In-flight reads dropped by a reset pulse; pointer restarts at requester 0.
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            drive(2'b01, 2'b00, 9'h005 + 9'(i), 9'h000, 32'h0, 32'h0, 4'h0, 4'h0);
            #1;
            check($sformatf("t6_grant%0d", i), 64'(req_ready), 64'(2'b01));
        end
        @(posedge clk);
        #1;
        idle();
        rst = 1'b1;
        #1;
        check("t6_rsp_during_rst", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("t6_no_rsp%0d", i), 64'(rsp_valid), 64'(0));
            @(posedge clk);
        end
        #1;
        drive(2'b11, 2'b00, 9'h001, 9'h002, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("t6_ptr_restart", 64'(req_ready), 64'(2'b01));

        // Asynchronous reset asserted mid-cycle with writes issuing and a response in flight.
        @(posedge clk);
        #1;
        drive(2'b01, 2'b01, 9'h020, 9'h000, 32'h12345678, 32'h0, 4'hF, 4'h0);
        #1;
        check("t1_grant0", 64'(req_ready), 64'(2'b01));
        @(posedge clk);
        #1;
        drive(2'b01, 2'b01, 9'h021, 9'h000, 32'h9ABCDEF0, 32'h0, 4'hF, 4'h0);
        #1;
        check("t1_grant1", 64'(req_ready), 64'(2'b01));
        @(posedge clk);
        #1;
        drive(2'b11, 2'b11, 9'h022, 9'h023, 32'h0, 32'h0, 4'hF, 4'hF);
        #1;
        check("t1_pre_csb0", 64'(sram_csb0), 64'(0));
        check("t1_pre_web0", 64'(sram_web0), 64'(0));
        check("t1_pre_wmask0", 64'(sram_wmask0), 64'(4'hF));
        check("t1_pre_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        #1;
        rst = 1'b1;
        #1;
        check("t1_csb0", 64'(sram_csb0), 64'(1));
        check("t1_web0", 64'(sram_web0), 64'(1));
        check("t1_wmask0", 64'(sram_wmask0), 64'(0));
        check("t1_ready", 64'(req_ready), 64'(0));
        check_rsp("t1", 2'b00, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(2'b11, 2'b00, 9'h001, 9'h002, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("t1_ptr_after", 64'(req_ready), 64'(2'b01));
        @(posedge clk);
        #1;
        idle();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
